// File: rtl/fruit_launcher_if.sv
// Spawn bus between the fruit launcher and the fruit_motion array: per-slot
// free flags in, one-hot launch strobe plus shared spawn position/velocity out.
interface fruit_launcher_if #(
  parameter int N_FRUITS = 4
);
  logic [N_FRUITS-1:0] out_of_screen;
  logic [N_FRUITS-1:0] Initialize;
  logic signed [31:0]  X_Pos_Init;
  logic signed [31:0]  Y_Pos_Init;
  logic signed [31:0]  X_V_Init;
  logic signed [31:0]  Y_V_Init;

  modport master (
    input  out_of_screen,
    output Initialize, X_Pos_Init, Y_Pos_Init, X_V_Init, Y_V_Init
  );

  modport slave (
    output out_of_screen,
    input  Initialize, X_Pos_Init, Y_Pos_Init, X_V_Init, Y_V_Init
  );
endinterface

// File: rtl/fruit_launcher.sv
// Decides when and where each fruit spawns: waits a frame interval, picks the
// lowest free slot, then strobes it with LFSR-derived spawn position/velocity.
module fruit_launcher #(
  parameter int          N_FRUITS          = 4,
  parameter int          LAUNCH_INTERVAL   = 45,
  parameter int          FRUIT_HEIGHT_HALF = 32,
  parameter int          SPAWN_X_MIN       = 64,
  parameter logic [15:0] SEED              = 16'hACE1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk_rising_edge,
  input  logic                    game_enable,
  fruit_launcher_if.master        fruit,
  output logic [15:0]             launch_count,
  output logic                    busy
);

  localparam int CNT_W = $clog2(LAUNCH_INTERVAL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SELECT,
    S_ISSUE
  } state_e;

  typedef struct packed {
    logic signed [31:0] x_pos;
    logic signed [31:0] y_pos;
    logic signed [31:0] x_v;
    logic signed [31:0] y_v;
  } spawn_t;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     interval_q, interval_d;
  logic [N_FRUITS-1:0]  initialize_q, initialize_d;
  spawn_t               spawn_q, spawn_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          count_q, count_d;
  logic                 busy_q, busy_d;

  logic [N_FRUITS-1:0]  lowest_free;
  logic [15:0]          lfsr_next;
  logic                 consume;
  spawn_t               spawn_new;

  // Isolates the lowest set bit, so simultaneous frees launch lowest index first.
  assign lowest_free = fruit.out_of_screen & (~fruit.out_of_screen + N_FRUITS'(1));
  assign lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign consume     = (state_q == S_ISSUE) && frame_clk_rising_edge;

  always_comb begin
    spawn_new       = '0;
    spawn_new.x_pos = 32'(SPAWN_X_MIN) + $signed({23'b0, lfsr_q[12:4]});
    spawn_new.y_pos = 32'(479 + FRUIT_HEIGHT_HALF);
    spawn_new.x_v   = (spawn_new.x_pos < 32'sd320) ? $signed({30'b0, lfsr_q[1:0]})
                                                   : -$signed({30'b0, lfsr_q[1:0]});
    spawn_new.y_v   = -32'sd6 - $signed({30'b0, lfsr_q[3:2]});
  end

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    interval_d   = interval_q;
    initialize_d = initialize_q;
    spawn_d      = spawn_q;
    lfsr_d       = lfsr_q;
    count_d      = count_q;

    if (state_q != S_IDLE && !game_enable) begin
      state_d      = S_IDLE;
      initialize_d = '0;
      if (consume) begin
        lfsr_d  = lfsr_next;
        count_d = count_q + 16'd1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (game_enable) begin
            state_d    = S_WAIT;
            interval_d = '0;
          end
        end
        S_WAIT: begin
          if (frame_clk_rising_edge) begin
            interval_d = interval_q + CNT_W'(1);
            if (interval_d == CNT_W'(LAUNCH_INTERVAL)) state_d = S_SELECT;
          end
        end
        S_SELECT: begin
          if (|fruit.out_of_screen) begin
            initialize_d = lowest_free;
            spawn_d      = spawn_new;
            state_d      = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (consume) begin
            initialize_d = '0;
            lfsr_d       = lfsr_next;
            count_d      = count_q + 16'd1;
            interval_d   = '0;
            state_d      = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      interval_q   <= '0;
      initialize_q <= '0;
      spawn_q      <= '0;
      lfsr_q       <= SEED;
      count_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      interval_q   <= interval_d;
      initialize_q <= initialize_d;
      spawn_q      <= spawn_d;
      lfsr_q       <= lfsr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
    end
  end

  assign fruit.Initialize = initialize_q;
  assign fruit.X_Pos_Init = spawn_q.x_pos;
  assign fruit.Y_Pos_Init = spawn_q.y_pos;
  assign fruit.X_V_Init   = spawn_q.x_v;
  assign fruit.Y_V_Init   = spawn_q.y_v;
  assign launch_count     = count_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Directed bench for fruit_launcher: expected launches are queued when stimulus
// is set up and popped when the Initialize strobe appears.
module tb_fruit_launcher;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [3:0] slot;
    int         x;
    int         y;
    int         xv;
    int         yv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame = 1'b0;
  logic        game_enable = 1'b0;
  logic [15:0] launch_count;
  logic        busy;

  logic        sw_en = 1'b0;
  logic [3:0]  sw_oos = 4'b1111;
  logic [3:0]  sw_init [3];
  int          sw_xp [3];
  int          sw_yp [3];
  int          sw_xv [3];
  int          sw_yv [3];
  logic [15:0] sw_cnt [3];
  logic        sw_busy [3];

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb [$];
  logic [15:0] model_l;

  always #5 clk = ~clk;

  fruit_launcher_if #(.N_FRUITS(4)) fl_if ();

  fruit_launcher #(
    .N_FRUITS(4), .LAUNCH_INTERVAL(2), .FRUIT_HEIGHT_HALF(32),
    .SPAWN_X_MIN(64), .SEED(SEED)
  ) dut (
    .Clk(clk), .Reset(rst), .frame_clk_rising_edge(frame),
    .game_enable(game_enable), .fruit(fl_if),
    .launch_count(launch_count), .busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    fruit_launcher_if #(.N_FRUITS(4)) sw_if ();
    assign sw_if.out_of_screen = sw_oos;
    fruit_launcher #(
      .N_FRUITS(4), .LAUNCH_INTERVAL(2), .FRUIT_HEIGHT_HALF(32), .SPAWN_X_MIN(64),
      .SEED(g == 0 ? 16'h0FFD : (g == 1 ? 16'h100D : 16'h1FFD))
    ) u_sw (
      .Clk(clk), .Reset(rst), .frame_clk_rising_edge(frame),
      .game_enable(sw_en), .fruit(sw_if),
      .launch_count(sw_cnt[g]), .busy(sw_busy[g])
    );
    assign sw_init[g] = sw_if.Initialize;
    assign sw_xp[g]   = sw_if.X_Pos_Init;
    assign sw_yp[g]   = sw_if.Y_Pos_Init;
    assign sw_xv[g]   = sw_if.X_V_Init;
    assign sw_yv[g]   = sw_if.Y_V_Init;
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic exp_t model(input logic [15:0] l, input logic [3:0] slot);
    exp_t e;
    int   m;
    e.slot = slot;
    e.x    = 64 + int'(l[12:4]);
    e.y    = 479 + 32;
    m      = int'(l[1:0]);
    e.xv   = (e.x < 320) ? m : -m;
    e.yv   = -6 - int'(l[3:2]);
    return e;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  // Two frame edges with idle Clks between them: enough for LAUNCH_INTERVAL=2.
  task automatic two_frames();
    pulse();
    tick();
    tick();
    pulse();
  endtask

  task automatic expect_launch(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (fl_if.Initialize == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".seen"}, longint'(|fl_if.Initialize), 1);
    e = sb.pop_front();
    check({tag, ".slot"}, longint'(fl_if.Initialize), longint'(e.slot));
    check({tag, ".x"},    longint'(fl_if.X_Pos_Init), longint'(e.x));
    check({tag, ".y"},    longint'(fl_if.Y_Pos_Init), longint'(e.y));
    check({tag, ".xv"},   longint'(fl_if.X_V_Init),   longint'(e.xv));
    check({tag, ".yv"},   longint'(fl_if.Y_V_Init),   longint'(e.yv));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".init"},  longint'(fl_if.Initialize), 0);
    check({tag, ".x"},     longint'(fl_if.X_Pos_Init), 0);
    check({tag, ".y"},     longint'(fl_if.Y_Pos_Init), 0);
    check({tag, ".xv"},    longint'(fl_if.X_V_Init),   0);
    check({tag, ".yv"},    longint'(fl_if.Y_V_Init),   0);
    check({tag, ".count"}, longint'(launch_count),     0);
    check({tag, ".busy"},  longint'(busy),             0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    int   exp_x [3];
    int   exp_xv [3];
    exp_x  = '{319, 320, 575};
    exp_xv = '{1, -1, -1};

    fl_if.out_of_screen = 4'b0000;
    model_l = SEED;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // 1: first launch from SEED lands in slot 0 with fixed field values
    game_enable = 1'b1;
    fl_if.out_of_screen = 4'b1111;
    e = '{slot: 4'b0001, x: 270, y: 511, xv: 1, yv: -6};
    sb.push_back(e);
    tick();
    check("t1.busy", longint'(busy), 1);
    pulse();
    check("t1.early", longint'(fl_if.Initialize), 0);
    tick();
    tick();
    pulse();
    expect_launch("t1");
    tick();
    tick();
    check("t1.hold", longint'(fl_if.Initialize), 1);
    fl_if.out_of_screen = 4'b1110;
    pulse();
    check("t1.drop", longint'(fl_if.Initialize), 0);
    check("t1.count", longint'(launch_count), 1);
    model_l = lfsr_step(model_l);

    // 2: slot 0 busy, next launch goes to slot 1 with advanced LFSR fields
    sb.push_back(model(model_l, 4'b0010));
    two_frames();
    expect_launch("t2");
    fl_if.out_of_screen = 4'b0000;
    pulse();
    check("t2.count", longint'(launch_count), 2);
    model_l = lfsr_step(model_l);

    // 3: no free slot for 10 frames, then only slot 3 frees
    two_frames();
    for (int i = 0; i < 10; i++) begin
      pulse();
      tick();
      tick();
      check("t3.busy", longint'(busy), 1);
      check("t3.idle_init", longint'(fl_if.Initialize), 0);
    end
    sb.push_back(model(model_l, 4'b1000));
    fl_if.out_of_screen = 4'b1000;
    tick();
    check("t3.rise", longint'(fl_if.Initialize), 8);
    expect_launch("t3");
    fl_if.out_of_screen = 4'b1111;
    pulse();
    check("t3.count", longint'(launch_count), 3);
    model_l = lfsr_step(model_l);

    // 4a: enable drop mid-ISSUE without a frame edge leaves the launch unconsumed
    sb.push_back(model(model_l, 4'b0001));
    two_frames();
    expect_launch("t4a");
    game_enable = 1'b0;
    tick();
    check("t4a.init", longint'(fl_if.Initialize), 0);
    check("t4a.busy", longint'(busy), 0);
    check("t4a.count", longint'(launch_count), 3);
    game_enable = 1'b1;
    sb.push_back(model(model_l, 4'b0001));
    tick();
    two_frames();
    expect_launch("t4a.relaunch");

    // 4b: enable drop coincident with a frame edge consumes the launch
    game_enable = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("t4b.init", longint'(fl_if.Initialize), 0);
    check("t4b.busy", longint'(busy), 0);
    check("t4b.count", longint'(launch_count), 4);
    model_l = lfsr_step(model_l);

    // 5: reset during ISSUE restores everything, LFSR back to SEED
    game_enable = 1'b1;
    sb.push_back(model(model_l, 4'b0001));
    tick();
    two_frames();
    expect_launch("t5.pre");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("t5.reset");
    model_l = SEED;
    e = '{slot: 4'b0001, x: 270, y: 511, xv: 1, yv: -6};
    sb.push_back(e);
    tick();
    two_frames();
    expect_launch("t5.post");

    // 6: field sweep across the X sign boundary with L[3:2]=11
    sw_en = 1'b1;
    tick();
    two_frames();
    n = 0;
    while ((sw_init[0] == 4'b0000 || sw_init[1] == 4'b0000 || sw_init[2] == 4'b0000) && n < 40) begin
      tick();
      n++;
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("t6.%0d.init", g),  longint'(sw_init[g]), 1);
      check($sformatf("t6.%0d.x", g),     longint'(sw_xp[g]), longint'(exp_x[g]));
      check($sformatf("t6.%0d.y", g),     longint'(sw_yp[g]), 511);
      check($sformatf("t6.%0d.xv", g),    longint'(sw_xv[g]), longint'(exp_xv[g]));
      check($sformatf("t6.%0d.yv", g),    longint'(sw_yv[g]), -9);
      check($sformatf("t6.%0d.busy", g),  longint'(sw_busy[g]), 1);
      check($sformatf("t6.%0d.count", g), longint'(sw_cnt[g]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fruit_launcher.md
Name: fruit_launcher

Overview:
- Initiator side of the fruit spawn interface. Decides when and where each fruit enters the screen.
- Drives one-hot Initialize strobes plus shared initial position and velocity to N_FRUITS fruit_motion instances.
- Re-arms a slot only once its out_of_screen flag reports it free.
- Sits between the game-control FSM (game_enable) and the array of fruit_motion instances.

Parameters:
- N_FRUITS, 4, number of fruit slots driven.
- LAUNCH_INTERVAL, 45, frame edges between completion of one launch and the next selection.
- FRUIT_HEIGHT_HALF, 32, half sprite height; sets spawn Y.
- SPAWN_X_MIN, 64, leftmost spawn X; spawn X span is SPAWN_X_MIN..SPAWN_X_MIN+511.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk_rising_edge  in  1  one-Clk pulse per frame; same signal that feeds fruit_motion.
- game_enable  in  1  launching allowed while high.
- out_of_screen  in  N_FRUITS  per-slot free flag from fruit_motion.
- Initialize  out  N_FRUITS  one-hot launch strobe.
- X_Pos_Init, Y_Pos_Init  out  32 (int)  spawn position.
- X_V_Init, Y_V_Init  out  32 (int)  spawn velocity.
- launch_count  out  16  launches consumed since reset; wraps at 65535->0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock Clk; Reset synchronous, active-high. All outputs registered.
- Reset values: state IDLE; Initialize=0; X/Y_Pos_Init=0; X/Y_V_Init=0; launch_count=0; busy=0; interval counter=0; LFSR=SEED.
- LFSR: 16-bit Fibonacci, shift left, new bit0 = l[15]^l[13]^l[12]^l[10]. Advances exactly once per consumed launch, never otherwise.
- Field mapping from the current LFSR value L:
  - X_Pos_Init = SPAWN_X_MIN + L[12:4] (unsigned, 0..511).
  - Y_Pos_Init = 479 + FRUIT_HEIGHT_HALF. This keeps the fruit just inside the out_of_screen bound.
  - Speed magnitude m = L[1:0] (0..3). X_V_Init = +m if X_Pos_Init < 320, else -m.
  - Y_V_Init = -6 - L[3:2] (range -6..-9).
- States and transitions:
  - IDLE: leave when game_enable=1 -> WAIT; interval counter cleared.
  - WAIT: interval counter increments on each frame_clk_rising_edge. When it reaches LAUNCH_INTERVAL -> SELECT.
  - SELECT: picks the lowest index i with out_of_screen[i]=1, evaluated every Clk. On a hit, latch i and the field values -> ISSUE. With no free slot, remain in SELECT indefinitely.
  - ISSUE: Initialize[i]=1, with all Init values stable from the first ISSUE cycle. The launch is consumed in the first ISSUE cycle where frame_clk_rising_edge=1. On the next Clk: Initialize=0, LFSR advances, launch_count+1, interval counter=0 -> WAIT.
- Latency: Initialize rises 1 Clk after SELECT finds a free slot. It is held for at most one frame period plus 1 Clk.
- Values: Init values hold their last launch values outside ISSUE; they are never X.
- game_enable drop: in any non-IDLE state, go to IDLE on the next Clk and clear Initialize.
  - If the drop cycle coincides with frame_clk_rising_edge while Initialize=1, the launch counts as consumed: launch_count increments and the LFSR advances.
  - A pending slot otherwise stays unlaunched.
- Simultaneous frees: when several out_of_screen bits are high, only the lowest index is launched. The others are taken by later launches.
- Reset during ISSUE: Initialize=0 on the next Clk, no count increment, LFSR returns to SEED.

Test Plan:
1. Reset; game_enable=1; all out_of_screen=1; LAUNCH_INTERVAL=2 -> after 2 frame edges, Initialize=4'b0001 with X_Pos_Init=270, Y_Pos_Init=511, X_V_Init=+1, Y_V_Init=-6. Drops 1 Clk after the next frame edge; launch_count=1.
2. Continue with out_of_screen[0] forced 0 after the launch -> the next launch goes to slot 1 with fields from the advanced LFSR (bench model). It never selects slot 0.
3. All out_of_screen=0 for 10 frames, then out_of_screen[3]=1 -> stays in SELECT with busy=1 and Initialize=0. Initialize=4'b1000 one Clk after the bit rises.
4. game_enable dropped mid-ISSUE with no frame edge -> Initialize=0 next Clk, state IDLE, launch_count unchanged. Repeat with the drop coincident with a frame edge -> launch_count increments.
5. Reset asserted during ISSUE -> all outputs return to reset values next Clk. The first launch after re-enable again yields X=270, Y_V=-6.
6. Field sweep: preload via SEED values giving X_Pos_Init at 319, 320 and 575 and L[3:2]=11 -> signs +, -, - respectively; Y_V_Init=-9.
